// File: rtl/booth_shift_reg.sv
// booth_shift_reg
//   Shift register for a radix-2 Booth multiplier datapath. A load captures
//   the operand and starts an operation. Each accepted shift_en then moves
//   the register one place right and records the bit shifted out as Q(-1).
//   After SHIFTS shifts the block parks in DONE until the next load.
//
// Parameters
//   WIDTH   register width in bits (>= 2)
//   SHIFTS  shifts per operation (1..WIDTH)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   load       in   parallel load strobe (wins over shift_en)
//   load_data  in   [WIDTH-1:0] value captured on load
//   shift_en   in   shift request, honoured only while busy
//   serial_in  in   MSB fill bit for a logical right shift (LSB fill for a left shift)
//   arith      in   1 = arithmetic right shift, 0 = logical right shift
//   dir        in   only when SHIFT_DIR_EN is defined: 1 = left shift
//   q          out  [WIDTH-1:0] register contents
//   q_m1       out  last bit shifted out (Booth Q(-1))
//   count      out  [$clog2(SHIFTS+1)-1:0] shifts since the last load
//   busy       out  operation in progress
//   done       out  SHIFTS shifts completed, held until the next load
//
// Optional feature
//   SHIFT_DIR_EN  when defined, adds the dir input and enables left shifts.
//
// state | meaning
// IDLE  | after reset, waiting for the first load
// RUN   | operand loaded, shifts being accepted
// DONE  | SHIFTS shifts done, shift_en ignored until the next load
module booth_shift_reg #(
    parameter int WIDTH  = 8,
    parameter int SHIFTS = WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [WIDTH-1:0]            load_data,
    input  logic                        shift_en,
    input  logic                        serial_in,
    input  logic                        arith,
`ifdef SHIFT_DIR_EN
    input  logic                        dir,
`endif
    output logic [WIDTH-1:0]            q,
    output logic                        q_m1,
    output logic [$clog2(SHIFTS+1)-1:0] count,
    output logic                        busy,
    output logic                        done
);

    localparam int CW = $clog2(SHIFTS + 1);
    localparam logic [CW-1:0] LAST_SHIFT = CW'(SHIFTS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   shift_fire;
    logic   fill;
    logic   left;

`ifdef SHIFT_DIR_EN
    assign left = dir;
`else
    assign left = 1'b0;
`endif

    // load takes priority, so a shift is only accepted on a cycle without one
    assign shift_fire = !load && (state == RUN) && shift_en;
    assign fill       = arith ? q[WIDTH-1] : serial_in;

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = RUN;
        end else if (shift_fire && (count == LAST_SHIFT)) begin
            state_nxt = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            // busy/done are flopped from the next state, not decoded from the state register
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
            if (load) begin
                q     <= load_data;
                q_m1  <= 1'b0;
                count <= '0;
            end else if (shift_fire) begin
                if (left) begin
                    q    <= {q[WIDTH-2:0], serial_in};
                    q_m1 <= q[WIDTH-1];
                end else begin
                    q    <= {fill, q[WIDTH-1:1]};
                    q_m1 <= q[0];
                end
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_booth_shift_reg.sv
module tb_booth_shift_reg;

    localparam int W  = 8;
    localparam int NS = 8;
    localparam int CW = $clog2(NS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  load_data = '0;
    logic          shift_en = 1'b0;
    logic          serial_in = 1'b0;
    logic          arith = 1'b0;
`ifdef SHIFT_DIR_EN
    logic          dir = 1'b0;
`endif
    logic [W-1:0]  q;
    logic          q_m1;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;

    booth_shift_reg #(.WIDTH(W), .SHIFTS(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .shift_en  (shift_en),
        .serial_in (serial_in),
        .arith     (arith),
`ifdef SHIFT_DIR_EN
        .dir       (dir),
`endif
        .q         (q),
        .q_m1      (q_m1),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int q_m1;
        int count;
        int busy;
        int done;
    } exp_t;

    exp_t exp_q[$];

    // reference model: plain integers, "active" means an operation is under way
    int m_q, m_qm1, m_cnt, m_active, m_finished;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_qm1 = 0; m_cnt = 0; m_active = 0; m_finished = 0;
    endtask

    task automatic model_step(input int ld, input int ldv, input int sh,
                              input int ar, input int sin, input int dr);
        int msb;
        if (ld != 0) begin
            m_q = ldv; m_qm1 = 0; m_cnt = 0; m_active = 1; m_finished = 0;
        end else if (m_active != 0 && sh != 0) begin
            if (dr != 0) begin
                m_qm1 = (m_q >> (W - 1)) & 1;
                m_q   = ((m_q * 2) + sin) % (1 << W);
            end else begin
                msb   = (ar != 0) ? ((m_q >> (W - 1)) & 1) : sin;
                m_qm1 = m_q % 2;
                m_q   = (m_q / 2) + msb * (1 << (W - 1));
            end
            m_cnt++;
            if (m_cnt == NS) begin
                m_active = 0; m_finished = 1;
            end
        end
    endtask

    // drive one cycle of stimulus, queue what the DUT must show after the edge,
    // and return shortly after that edge so callers can add direct checks
    task automatic cyc(input int ld, input int ldv, input int sh,
                       input int ar, input int sin, input int dr);
        exp_t e;
        @(negedge clk);
        load      = (ld != 0);
        load_data = W'(ldv);
        shift_en  = (sh != 0);
        arith     = (ar != 0);
        serial_in = (sin != 0);
`ifdef SHIFT_DIR_EN
        dir       = (dr != 0);
`endif
        model_step(ld, ldv, sh, ar, sin, dr);
        e.q = m_q; e.q_m1 = m_qm1; e.count = m_cnt; e.busy = m_active; e.done = m_finished;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // monitor: every edge that has a queued expectation is compared
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("q",     int'(q),     e.q);
            chk("q_m1",  int'(q_m1),  e.q_m1);
            chk("count", int'(count), e.count);
            chk("busy",  int'(busy),  e.busy);
            chk("done",  int'(done),  e.done);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q",    int'(q),     0);
        chk("reset_busy", int'(busy),  0);
        chk("reset_done", int'(done),  0);
        @(negedge clk);
        rst = 1'b0;

        // idle after reset: shift_en ignored
        cyc(0, 0, 1, 0, 1, 0);
        chk("idle_hold_q", int'(q), 0);

        // arithmetic shifts of 0x96
        cyc(1, 'h96, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0, 0);
        chk("arith1_q", int'(q), 'hCB);
        chk("arith1_qm1", int'(q_m1), 0);
        cyc(0, 0, 1, 1, 0, 0);
        chk("arith2_q", int'(q), 'hE5);
        chk("arith2_qm1", int'(q_m1), 1);
        chk("arith2_count", int'(count), 2);

        // RUN with shift_en low holds
        cyc(0, 0, 0, 1, 1, 0);
        chk("run_hold_q", int'(q), 'hE5);

        // logical shift of 0x96
        cyc(1, 'h96, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        chk("logic_q", int'(q), 'h4B);
        chk("logic_qm1", int'(q_m1), 0);

        // full operation then an ignored 9th shift
        cyc(1, 'h01, 0, 0, 0, 0);
        for (int i = 0; i < NS; i++) cyc(0, 0, 1, 0, 0, 0);
        chk("full_q", int'(q), 0);
        chk("full_count", int'(count), NS);
        chk("full_done", int'(done), 1);
        chk("full_busy", int'(busy), 0);
        cyc(0, 0, 1, 0, 1, 0);
        chk("ninth_count", int'(count), NS);
        chk("ninth_q", int'(q), 0);

        // load beats shift_en
        cyc(1, 'h55, 1, 0, 1, 0);
        chk("ldwin_q", int'(q), 'h55);
        chk("ldwin_count", int'(count), 0);
        chk("ldwin_busy", int'(busy), 1);

`ifdef SHIFT_DIR_EN
        cyc(1, 'h81, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 1);
        chk("left_q", int'(q), 'h03);
        chk("left_qm1", int'(q_m1), 1);
`endif

        // async reset between edges after 3 shifts
        cyc(1, 'hA7, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk("arst_q", int'(q), 0);
        chk("arst_qm1", int'(q_m1), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 1, 0);
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_q", int'(q), 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) == 0) ? 1 : 0,
                int'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)),
                0);
        end

        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_shift_reg.md
BOOTH_SHIFT_REG -- requirements
Module: booth_shift_reg

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter WIDTH, default 8, SHALL set the register width in bits (minimum 2).
REQ-003 Parameter SHIFTS, default WIDTH, SHALL set the number of shifts per operation (1..WIDTH).
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  asynchronous active-high reset.
REQ-006 Port load  input  1  parallel load strobe.
REQ-007 Port load_data  input  WIDTH  value captured on load.
REQ-008 Port shift_en  input  1  shift request for the current cycle.
REQ-009 Port serial_in  input  1  fill bit for a logical shift.
REQ-010 Port arith  input  1  1 = arithmetic right shift (MSB replicated); 0 = logical right shift (serial_in fills the MSB).
REQ-011 Port q  output  WIDTH  register contents.
REQ-012 Port q_m1  output  1  Booth Q(-1) bit: the last bit shifted out.
REQ-013 Port count  output  $clog2(SHIFTS+1)  shifts completed since the last load.
REQ-014 Port busy  output  1  operation in progress.
REQ-015 Port done  output  1  SHIFTS shifts completed; held high until the next load.

Function
REQ-016 All outputs SHALL be registered and update only on a rising clk edge, except on reset.
REQ-017 States SHALL be IDLE (busy=0, done=0), RUN (busy=1) and DONE (done=1).
REQ-018 On load in any state: q<=load_data, q_m1<=0, count<=0, done<=0, busy<=1 (go to RUN).
REQ-019 If load and shift_en are asserted in the same cycle, load SHALL win and no shift SHALL occur.
REQ-020 In RUN with shift_en=1, a right shift SHALL occur: q<={fill, q[WIDTH-1:1]}, q_m1<=q[0], count<=count+1.
REQ-021 The fill bit SHALL be q[WIDTH-1] when arith=1 and serial_in when arith=0.
REQ-022 On the shift that makes count equal SHIFTS, the same edge SHALL set busy<=0 and done<=1 (go to DONE).
REQ-023 In RUN with shift_en=0, all registers SHALL hold (no clear-on-idle).
REQ-024 In IDLE or DONE, shift_en SHALL be ignored and q, q_m1 and count SHALL hold.
REQ-025 count SHALL never exceed SHIFTS and SHALL never wrap.
REQ-026 Latency SHALL be one cycle from a load or shift_en edge to the visible q update.

Reset
REQ-027 rst=1 SHALL immediately force q=0, q_m1=0, count=0, busy=0, done=0 and the state to IDLE, including mid-operation.
REQ-028 After rst deasserts, the block SHALL remain in IDLE until a load occurs.

Configuration
REQ-029 Macro SHIFT_DIR_EN, when defined, SHALL add port dir (input, 1 bit); when it is absent the port SHALL NOT exist.
REQ-030 With SHIFT_DIR_EN defined and dir=1, a shift SHALL be left: q<={q[WIDTH-2:0], serial_in}, q_m1<=q[WIDTH-1], arith ignored.
REQ-031 With SHIFT_DIR_EN defined and dir=0, or with the macro undefined, behaviour SHALL be right-shift only, per REQ-020/021.

Verification (WIDTH=8, SHIFTS=8)
REQ-032 Load 0x96, arith=1, one shift -> q=0xCB, q_m1=0; second shift -> q=0xE5, q_m1=1, count=2.
REQ-033 Load 0x96, arith=0, serial_in=0, one shift -> q=0x4B, q_m1=0.
REQ-034 Load 0x01, arith=0, serial_in=0, 8 shifts -> q=0x00, count=8, done=1, busy=0; a 9th shift_en leaves every output unchanged.
REQ-035 Load and shift_en in the same cycle with load_data=0x55 -> q=0x55, count=0, busy=1.
REQ-036 rst pulse asserted between clock edges after 3 shifts -> all outputs 0 without waiting for a clock edge; shift_en afterwards is ignored until a load.
REQ-037 With SHIFT_DIR_EN defined: load 0x81, dir=1, serial_in=1, one shift -> q=0x03, q_m1=1.
